// File: rtl/mbus_timer_pkg.sv
// Shared register map and bit positions for the memory-mapped countdown timer.
// The same offsets and bit indices are mirrored in the firmware headers.
package mbus_timer_pkg;

    typedef enum logic [2:0] {
        TMR_CNTR  = 3'd0,
        TMR_RLD   = 3'd1,
        TMR_CTRL  = 3'd2,
        TMR_STAT  = 3'd3,
        TMR_PRESC = 3'd4
    } tmr_reg_e;

    localparam int TMR_RUN = 0;
    localparam int TMR_IE  = 1;
    localparam int TMR_AR  = 2;
    localparam int TMR_OVF = 0;

    localparam int PRESC_W = 16;

    // Field order puts run in bit 0 so the struct can be read back as-is.
    typedef struct packed {
        logic ar;
        logic ie;
        logic run;
    } tmr_ctrl_t;

endpackage

// File: rtl/mbus_timer_if.sv
// CPU memory-bus connection for the timer: the CPU is master, the timer is slave.
interface mbus_timer_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 32
);
    logic [ADDR_SIZE-1:0] mbus_ain;
    logic [WIDTH-1:0]     mbus_din;
    logic                 mbus_wen;
    logic [WIDTH-1:0]     mbus_dout;
    logic                 cs;
    logic                 irq;

    modport master (
        output mbus_ain, mbus_din, mbus_wen,
        input  mbus_dout, cs, irq
    );

    modport slave (
        input  mbus_ain, mbus_din, mbus_wen,
        output mbus_dout, cs, irq
    );
endinterface

// File: rtl/mbus_timer_presc.sv
// Prescaler: counts 0..limit while running and pulses tick on the terminal count.
// Stopping holds the count; clr restarts the count from zero.
module tmr_presc
    import mbus_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic [PRESC_W-1:0] i_limit,
    input  logic               i_clr,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_pcnt;

    assign o_tick = i_run && (r_pcnt == i_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (i_clr || o_tick) begin
            r_pcnt <= '0;
        end else if (i_run) begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/mbus_timer.sv
// Memory-mapped countdown timer: address decode, register file, prescaled down-counter
// with underflow interrupt, and a read mux that drives zero when not selected.
module mbus_timer
    import mbus_timer_pkg::*;
#(
    parameter int                   WIDTH     = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] BASE      = 32'hFFFF_FF40
) (
    input  logic        clk,
    input  logic        reset,
    mbus_timer_if.slave bus
);

    logic [WIDTH-1:0]   r_cntr;
    logic [WIDTH-1:0]   r_rld;
    tmr_ctrl_t          r_ctrl;
    logic               r_ovf;
    logic [PRESC_W-1:0] r_presc;

    logic               w_cs;
    logic               w_wr;
    tmr_reg_e           w_off;
    logic               w_wrCntr;
    logic               w_wrRld;
    logic               w_wrCtrl;
    logic               w_wrStat;
    logic               w_wrPresc;
    logic               w_tick;
    logic               w_zero;
    logic               w_under;
    logic               w_prescClr;
    logic [WIDTH-1:0]   w_rdata;

    assign w_cs      = (bus.mbus_ain[ADDR_SIZE-1:3] == BASE[ADDR_SIZE-1:3]);
    assign w_wr      = bus.mbus_wen && w_cs;
    assign w_off     = tmr_reg_e'(bus.mbus_ain[2:0]);
    assign w_wrCntr  = w_wr && (w_off == TMR_CNTR);
    assign w_wrRld   = w_wr && (w_off == TMR_RLD);
    assign w_wrCtrl  = w_wr && (w_off == TMR_CTRL);
    assign w_wrStat  = w_wr && (w_off == TMR_STAT);
    assign w_wrPresc = w_wr && (w_off == TMR_PRESC);

    // Restarting the timer or changing the limit always begins a fresh prescale period.
    assign w_prescClr = w_wrPresc ||
                        (w_wrCtrl && bus.mbus_din[TMR_RUN] && !r_ctrl.run);

    tmr_presc u_presc (
        .clk     (clk),
        .reset   (reset),
        .i_run   (r_ctrl.run),
        .i_limit (r_presc),
        .i_clr   (w_prescClr),
        .o_tick  (w_tick)
    );

    assign w_zero  = (r_cntr == '0);
    assign w_under = w_tick && w_zero;

    // CPU writes take priority over counter updates, except that an underflow always sets ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cntr  <= '0;
            r_rld   <= '0;
            r_ctrl  <= '0;
            r_ovf   <= 1'b0;
            r_presc <= '0;
        end else begin
            if (w_wrCntr) begin
                r_cntr <= bus.mbus_din;
            end else if (w_tick) begin
                if (!w_zero) begin
                    r_cntr <= r_cntr - 1'b1;
                end else if (r_ctrl.ar) begin
                    r_cntr <= r_rld;
                end
            end

            if (w_wrRld) begin
                r_rld <= bus.mbus_din;
            end

            if (w_wrCtrl) begin
                r_ctrl.run <= bus.mbus_din[TMR_RUN];
                r_ctrl.ie  <= bus.mbus_din[TMR_IE];
                r_ctrl.ar  <= bus.mbus_din[TMR_AR];
            end else if (w_under && !r_ctrl.ar) begin
                r_ctrl.run <= 1'b0;
            end

            if (w_under) begin
                r_ovf <= 1'b1;
            end else if (w_wrStat && bus.mbus_din[TMR_OVF]) begin
                r_ovf <= 1'b0;
            end

            if (w_wrPresc) begin
                r_presc <= bus.mbus_din[PRESC_W-1:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            TMR_CNTR:  w_rdata = r_cntr;
            TMR_RLD:   w_rdata = r_rld;
            TMR_CTRL:  w_rdata = {{(WIDTH-3){1'b0}}, r_ctrl};
            TMR_STAT:  w_rdata = {{(WIDTH-1){1'b0}}, r_ovf};
            TMR_PRESC: w_rdata = {{(WIDTH-PRESC_W){1'b0}}, r_presc};
            default:   w_rdata = '0;
        endcase
    end

    assign bus.mbus_dout = w_cs ? w_rdata : '0;
    assign bus.cs        = w_cs;
    assign bus.irq       = r_ovf && r_ctrl.ie;

endmodule

// File: tb/tb_mbus_timer.sv
// Self-checking bench for mbus_timer: directed scenarios followed by random bus traffic,
// all compared against a cycle-level behavioural model of the timer.
`timescale 1ns/1ps
module tb_mbus_timer;

    localparam logic [31:0] BASE = 32'hFFFF_FF40;

    logic clk;
    logic reset;

    mbus_timer_if #(.WIDTH(32), .ADDR_SIZE(32)) bus ();

    mbus_timer #(.WIDTH(32), .ADDR_SIZE(32), .BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    int vecCount  = 0;
    int missCount = 0;

    logic [31:0] mCnt, mRld;
    logic [15:0] mPresc, mPc;
    bit          mRun, mIe, mAr, mOvf;

    function automatic void modelReset();
        mCnt = 0; mRld = 0; mPresc = 0; mPc = 0;
        mRun = 0; mIe = 0; mAr = 0; mOvf = 0;
    endfunction

    function automatic bit inWindow(input logic [31:0] a);
        return a[31:3] == BASE[31:3];
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (!inWindow(a)) return 32'd0;
        case (a[2:0])
            3'd0:    return mCnt;
            3'd1:    return mRld;
            3'd2:    return {29'd0, mAr, mIe, mRun};
            3'd3:    return {31'd0, mOvf};
            3'd4:    return {16'd0, mPresc};
            default: return 32'd0;
        endcase
    endfunction

    // Advances the model across one clock edge given the bus request present before it.
    function automatic void modelStep(input bit w, input logic [31:0] a, input logic [31:0] d);
        bit tk, under, hit;
        logic [31:0] nCnt, nRld;
        logic [15:0] nPresc, nPc;
        bit nRun, nIe, nAr, nOvf;
        hit   = w && inWindow(a);
        tk    = mRun && (mPc == mPresc);
        under = tk && (mCnt == 0);
        nCnt = mCnt; nRld = mRld; nPresc = mPresc; nPc = mPc;
        nRun = mRun; nIe = mIe; nAr = mAr;
        if (mRun) nPc = tk ? 16'd0 : mPc + 16'd1;
        if (tk) begin
            if (mCnt != 0) nCnt = mCnt - 1;
            else if (mAr) nCnt = mRld;
            else nRun = 0;
        end
        nOvf = mOvf || under;
        if (hit) begin
            case (a[2:0])
                3'd0: nCnt = d;
                3'd1: nRld = d;
                3'd2: begin
                    if (d[0] && !mRun) nPc = 0;
                    nRun = d[0]; nIe = d[1]; nAr = d[2];
                end
                3'd3: if (d[0]) nOvf = under;
                3'd4: begin nPresc = d[15:0]; nPc = 0; end
                default: ;
            endcase
        end
        mCnt = nCnt; mRld = nRld; mPresc = nPresc; mPc = nPc;
        mRun = nRun; mIe = nIe; mAr = nAr; mOvf = nOvf;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        assert (got === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle of bus traffic; the model is stepped with the same request.
    task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.mbus_wen = w;
        bus.mbus_ain = a;
        bus.mbus_din = d;
        modelStep(w, a, d);
        @(posedge clk);
        #1;
        bus.mbus_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, BASE + 32'd16, 32'd0);
    endtask

    task automatic writeReg(input int off, input logic [31:0] d);
        applyStimulus(1'b1, BASE + 32'(off), d);
    endtask

    task automatic readReg(input int off, output logic [31:0] v);
        bus.mbus_ain = BASE + 32'(off);
        #1;
        v = bus.mbus_dout;
    endtask

    // Sweeps the window plus the first address past it, comparing every output.
    task automatic checkOutput(input string tag);
        logic [31:0] a;
        checkVal({tag, ".irq"}, {31'd0, bus.irq}, {31'd0, mOvf && mIe});
        for (int i = 0; i <= 8; i++) begin
            a = BASE + 32'(i);
            bus.mbus_ain = a;
            #1;
            checkVal($sformatf("%s.rd%0d", tag, i), bus.mbus_dout, modelRead(a));
            checkVal($sformatf("%s.cs%0d", tag, i), {31'd0, bus.cs}, {31'd0, inWindow(a)});
        end
    endtask

    logic [31:0] rv;
    logic [31:0] addr, data;
    int          sel;

    initial begin
        bus.mbus_wen = 1'b0;
        bus.mbus_ain = '0;
        bus.mbus_din = '0;
        reset = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;

        // Auto-reload run with PRESC=0: underflow every four cycles.
        writeReg(1, 32'd3);
        writeReg(0, 32'd3);
        writeReg(4, 32'd0);
        writeReg(2, 32'd7);
        idle(3);
        readReg(3, rv); checkVal("ar.ovfEarly", rv, 32'd0);
        idle(1);
        checkOutput("ar.first");
        readReg(3, rv); checkVal("ar.ovf", rv, 32'd1);
        checkVal("ar.irq", {31'd0, bus.irq}, 32'd1);
        readReg(0, rv); checkVal("ar.reload", rv, 32'd3);
        writeReg(3, 32'd1);
        idle(2);
        readReg(3, rv); checkVal("ar.cleared", rv, 32'd0);
        idle(1);
        readReg(3, rv); checkVal("ar.second", rv, 32'd1);

        // A CNTR write on a tick edge wins over the decrement.
        writeReg(0, 32'd9);
        readReg(0, rv); checkVal("wrTick.cntr", rv, 32'd9);

        // STAT clear on the underflow edge loses; STAT=0 never clears.
        writeReg(0, 32'd1);
        writeReg(3, 32'd1);
        readReg(3, rv); checkVal("w1c.cleared", rv, 32'd0);
        writeReg(3, 32'd1);
        readReg(3, rv); checkVal("w1c.setWins", rv, 32'd1);
        writeReg(3, 32'd0);
        readReg(3, rv); checkVal("w1c.zeroNoEffect", rv, 32'd1);
        writeReg(3, 32'd1);
        readReg(3, rv); checkVal("w1c.clear", rv, 32'd0);
        checkOutput("w1c");

        // One-shot with PRESC=2: stops itself, interrupt masked.
        writeReg(2, 32'd0);
        writeReg(3, 32'd1);
        writeReg(4, 32'd2);
        writeReg(0, 32'd1);
        writeReg(2, 32'd1);
        idle(2);
        readReg(0, rv); checkVal("os.cntrHold", rv, 32'd1);
        idle(1);
        readReg(0, rv); checkVal("os.cntrZero", rv, 32'd0);
        idle(2);
        readReg(3, rv); checkVal("os.ovfEarly", rv, 32'd0);
        idle(1);
        readReg(3, rv); checkVal("os.ovf", rv, 32'd1);
        readReg(2, rv); checkVal("os.stopped", rv, 32'd0);
        checkVal("os.irq", {31'd0, bus.irq}, 32'd0);
        checkOutput("oneShot");

        // Reserved offsets and the first address past the window are inert.
        writeReg(0, 32'h1234);
        for (int i = 5; i <= 8; i++) writeReg(i, 32'hFFFF_FFFF);
        readReg(0, rv); checkVal("rsv.cntr", rv, 32'h1234);
        checkOutput("reserved");

        // Reset mid-count clears everything at once.
        writeReg(4, 32'd0);
        writeReg(0, 32'd5);
        writeReg(2, 32'd3);
        idle(1);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        #1;
        readReg(0, rv); checkVal("rst.cntr", rv, 32'd0);
        checkOutput("midReset");
        #2;
        reset = 1'b0;

        // Random traffic, mostly small values so underflows happen often.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                addr = ($urandom_range(0, 9) == 0) ? BASE + 32'd8 : BASE + 32'($urandom_range(0, 7));
                data = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 7));
                if (addr[2:0] == 3'd4 && data > 32'd3) data = 32'($urandom_range(0, 3));
                applyStimulus(1'b1, addr, data);
            end else begin
                applyStimulus(1'b0, $urandom, $urandom);
            end
            checkOutput($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
